// File: rtl/user_mgr_mux.sv
// Round-robin OBI manager multiplexer: merges NumMgr user managers onto one port
// and routes each response back through an in-order FIFO of granted indices.
module user_mgr_mux #(
  parameter int NumMgr    = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int MaxTrans  = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumMgr-1:0]                 sbr_req_i,
  output logic [NumMgr-1:0]                 sbr_gnt_o,
  input  logic [NumMgr*AddrWidth-1:0]       sbr_addr_i,
  input  logic [NumMgr-1:0]                 sbr_we_i,
  input  logic [NumMgr*(DataWidth/8)-1:0]   sbr_be_i,
  input  logic [NumMgr*DataWidth-1:0]       sbr_wdata_i,
  output logic [NumMgr-1:0]                 sbr_rvalid_o,
  output logic [DataWidth-1:0]              sbr_rdata_o,
  output logic                              sbr_err_o,
  output logic                              mgr_req_o,
  input  logic                              mgr_gnt_i,
  output logic [AddrWidth-1:0]              mgr_addr_o,
  output logic                              mgr_we_o,
  output logic [DataWidth/8-1:0]            mgr_be_o,
  output logic [DataWidth-1:0]              mgr_wdata_o,
  input  logic                              mgr_rvalid_i,
  input  logic [DataWidth-1:0]              mgr_rdata_i,
  input  logic                              mgr_err_i,
  output logic                              busy_o,
  output logic                              proto_err_o
);

  localparam int BeWidth = DataWidth / 8;
  localparam int IdxW    = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  localparam int PtrW    = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int CntW    = $clog2(MaxTrans + 1);

  logic [IdxW-1:0] rr;
  logic [IdxW-1:0] lock_idx;
  logic            lock_valid;
  logic [IdxW-1:0] sel;
  logic [IdxW-1:0] head;
  logic            any_req;
  logic            handshake;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [IdxW-1:0] order_mem [MaxTrans];
  logic [PtrW-1:0] wptr;
  logic [PtrW-1:0] rptr;
  logic [CntW-1:0] count;
  logic            proto_err;

  // A held lock wins; otherwise scan from rr with wrap-around.
  always_comb begin : arbiter
    logic found;
    int   idx;
    sel   = rr;
    found = 1'b0;
    idx   = 0;
    if (lock_valid && sbr_req_i[lock_idx]) begin
      sel = lock_idx;
    end else begin
      for (int k = 0; k < NumMgr; k++) begin
        idx = (int'(rr) + k) % NumMgr;
        if (!found && sbr_req_i[IdxW'(idx)]) begin
          sel   = IdxW'(idx);
          found = 1'b1;
        end
      end
    end
  end

  assign any_req    = |sbr_req_i;
  assign fifo_full  = (count == CntW'(MaxTrans));
  assign fifo_empty = (count == '0);
  assign mgr_req_o  = any_req && !fifo_full && !rst_i;
  assign handshake  = mgr_req_o && mgr_gnt_i;
  assign push       = handshake;
  assign pop        = mgr_rvalid_i && !fifo_empty && !rst_i;
  assign head       = order_mem[rptr];

  assign mgr_addr_o  = sbr_addr_i[sel*AddrWidth +: AddrWidth];
  assign mgr_we_o    = sbr_we_i[sel];
  assign mgr_be_o    = sbr_be_i[sel*BeWidth +: BeWidth];
  assign mgr_wdata_o = sbr_wdata_i[sel*DataWidth +: DataWidth];

  always_comb begin
    sbr_gnt_o = '0;
    if (handshake) sbr_gnt_o[sel] = 1'b1;
  end

  always_comb begin
    sbr_rvalid_o = '0;
    if (pop) sbr_rvalid_o[head] = 1'b1;
  end

  assign sbr_rdata_o = mgr_rdata_i;
  assign sbr_err_o   = mgr_err_i;
  assign busy_o      = !fifo_empty;
  assign proto_err_o = proto_err;

  always_ff @(posedge clk_i) begin
    if (push) order_mem[wptr] <= sel;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr         <= '0;
      lock_valid <= 1'b0;
      lock_idx   <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      proto_err  <= 1'b0;
    end else begin
      // A pending but ungranted selection is pinned so the A-channel stays stable.
      if (handshake) begin
        lock_valid <= 1'b0;
        rr         <= (sel == IdxW'(NumMgr - 1)) ? '0 : sel + 1'b1;
      end else if (any_req) begin
        lock_valid <= 1'b1;
        lock_idx   <= sel;
      end else begin
        lock_valid <= 1'b0;
      end

      if (push) wptr <= (wptr == PtrW'(MaxTrans - 1)) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == PtrW'(MaxTrans - 1)) ? '0 : rptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (mgr_rvalid_i && fifo_empty) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_user_mgr_mux.sv
// Directed self-checking bench for user_mgr_mux with NumMgr=2, MaxTrans=4.
module tb_user_mgr_mux;

  logic        clk;
  logic        rst;
  logic [1:0]  sbr_req;
  logic [1:0]  sbr_gnt;
  logic [63:0] sbr_addr;
  logic [1:0]  sbr_we;
  logic [7:0]  sbr_be;
  logic [63:0] sbr_wdata;
  logic [1:0]  sbr_rvalid;
  logic [31:0] sbr_rdata;
  logic        sbr_err;
  logic        mgr_req;
  logic        mgr_gnt;
  logic [31:0] mgr_addr;
  logic        mgr_we;
  logic [3:0]  mgr_be;
  logic [31:0] mgr_wdata;
  logic        mgr_rvalid;
  logic [31:0] mgr_rdata;
  logic        mgr_err;
  logic        busy;
  logic        proto_err;

  int checks_total;
  int checks_passed;

  user_mgr_mux #(
    .NumMgr(2), .AddrWidth(32), .DataWidth(32), .MaxTrans(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .sbr_req_i(sbr_req),
    .sbr_gnt_o(sbr_gnt),
    .sbr_addr_i(sbr_addr),
    .sbr_we_i(sbr_we),
    .sbr_be_i(sbr_be),
    .sbr_wdata_i(sbr_wdata),
    .sbr_rvalid_o(sbr_rvalid),
    .sbr_rdata_o(sbr_rdata),
    .sbr_err_o(sbr_err),
    .mgr_req_o(mgr_req),
    .mgr_gnt_i(mgr_gnt),
    .mgr_addr_o(mgr_addr),
    .mgr_we_o(mgr_we),
    .mgr_be_o(mgr_be),
    .mgr_wdata_o(mgr_wdata),
    .mgr_rvalid_i(mgr_rvalid),
    .mgr_rdata_i(mgr_rdata),
    .mgr_err_i(mgr_err),
    .busy_o(busy),
    .proto_err_o(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled right after.
  task automatic applyStimulus(input logic [1:0] req, input logic gnt, input logic rvalid,
                               input logic [31:0] rdata);
    sbr_req    = req;
    mgr_gnt    = gnt;
    mgr_rvalid = rvalid;
    mgr_rdata  = rdata;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_rr [4];
    exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;
    checks_total  = 0;
    checks_passed = 0;
    rst        = 1'b1;
    sbr_req    = '0;
    sbr_addr   = {32'h0000_1100, 32'h0000_1000};
    sbr_we     = 2'b00;
    sbr_be     = 8'hFF;
    sbr_wdata  = '0;
    mgr_gnt    = 1'b0;
    mgr_rvalid = 1'b0;
    mgr_rdata  = '0;
    mgr_err    = 1'b0;

    // Reset state, with requests held high while reset is asserted
    nextCycle();
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h0);
    checkOutput("rst_mgr_req", mgr_req, 0);
    checkOutput("rst_gnt", sbr_gnt, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_proto", proto_err, 0);
    nextCycle();
    doReset();

    // Single manager read
    sbr_addr[31:0] = 32'h2000_0000;
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
    checkOutput("single_req", mgr_req, 1);
    checkOutput("single_gnt", sbr_gnt, 2'b01);
    checkOutput("single_addr", mgr_addr, 32'h2000_0000);
    checkOutput("single_busy0", busy, 0);
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("single_busy1", busy, 1);
    checkOutput("single_nortn", sbr_rvalid, 2'b00);
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF);
    mgr_err = 1'b1;
    #1;
    checkOutput("single_busy2", busy, 1);
    checkOutput("single_rvalid", sbr_rvalid, 2'b01);
    checkOutput("single_rdata", sbr_rdata, 32'hDEAD_BEEF);
    checkOutput("single_err", sbr_err, 1);
    mgr_err = 1'b0;
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("single_busy3", busy, 0);
    checkOutput("single_proto", proto_err, 0);

    // Round-robin alternation from manager 0 after reset
    doReset();
    sbr_addr = {32'h0000_1100, 32'h0000_1000};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11, 1'b1, 1'b0, 32'h0);
      checkOutput($sformatf("rr_gnt%0d", i), sbr_gnt, exp_rr[i]);
      checkOutput($sformatf("rr_addr%0d", i), mgr_addr, (i % 2 == 0) ? 32'h1000 : 32'h1100);
      nextCycle();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b00, 1'b0, 1'b1, 32'hA000_0000 + i);
      checkOutput($sformatf("rr_rvalid%0d", i), sbr_rvalid, exp_rr[i]);
      nextCycle();
    end
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("rr_busy_end", busy, 0);

    // Lock: manager 1 stalls, manager 0 arrives later but must wait
    doReset();
    sbr_we    = 2'b10;
    sbr_wdata = {32'hCAFE_0001, 32'h0000_0000};
    applyStimulus(2'b10, 1'b0, 1'b0, 32'h0);
    checkOutput("lock_addr0", mgr_addr, 32'h1100);
    checkOutput("lock_gnt0", sbr_gnt, 2'b00);
    nextCycle();
    applyStimulus(2'b11, 1'b0, 1'b0, 32'h0);
    checkOutput("lock_addr1", mgr_addr, 32'h1100);
    nextCycle();
    applyStimulus(2'b11, 1'b0, 1'b0, 32'h0);
    checkOutput("lock_addr2", mgr_addr, 32'h1100);
    checkOutput("lock_we", mgr_we, 1);
    checkOutput("lock_wdata", mgr_wdata, 32'hCAFE_0001);
    nextCycle();
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h0);
    checkOutput("lock_gnt_m1", sbr_gnt, 2'b10);
    nextCycle();
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
    checkOutput("lock_gnt_m0", sbr_gnt, 2'b01);
    checkOutput("lock_addr_m0", mgr_addr, 32'h1000);
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h1);
    checkOutput("lock_rsp_m1", sbr_rvalid, 2'b10);
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h2);
    checkOutput("lock_rsp_m0", sbr_rvalid, 2'b01);
    nextCycle();
    sbr_we    = 2'b00;
    sbr_wdata = '0;

    // Full FIFO blocks requests, even with a same-cycle pop
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
      checkOutput($sformatf("full_gnt%0d", i), sbr_gnt, 2'b01);
      nextCycle();
    end
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
    checkOutput("full_req5", mgr_req, 0);
    checkOutput("full_gnt5", sbr_gnt, 2'b00);
    nextCycle();
    applyStimulus(2'b01, 1'b1, 1'b1, 32'h5);
    checkOutput("full_req_pop", mgr_req, 0);
    checkOutput("full_gnt_pop", sbr_gnt, 2'b00);
    checkOutput("full_rvalid_pop", sbr_rvalid, 2'b01);
    nextCycle();
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
    checkOutput("full_req_again", mgr_req, 1);
    checkOutput("full_gnt_again", sbr_gnt, 2'b01);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b00, 1'b0, 1'b1, 32'h0);
      checkOutput($sformatf("full_drain%0d", i), sbr_rvalid, 2'b01);
      nextCycle();
    end
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("full_busy_end", busy, 0);
    checkOutput("full_proto", proto_err, 0);

    // Orphan response sets a sticky error
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h0);
    checkOutput("orph_rvalid", sbr_rvalid, 2'b00);
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("orph_proto1", proto_err, 1);
    nextCycle();
    nextCycle();
    checkOutput("orph_proto_hold", proto_err, 1);
    doReset();
    checkOutput("orph_proto_clr", proto_err, 0);

    // Reset with three transactions outstanding
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b11, 1'b1, 1'b0, 32'h0);
      nextCycle();
    end
    checkOutput("mid_busy_pre", busy, 1);
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("mid_req_in_rst", mgr_req, 0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h7);
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_rvalid", sbr_rvalid, 2'b00);
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("mid_proto", proto_err, 1);

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
